// File: rtl/scan_index_gen.sv
// Scan sequencer feeding a 3-to-8 one-hot decoder: steps a digit index through
// the enabled positions with a blanking gap before each digit and a frame-wrap pulse.
module scan_index_gen #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             dir,
    input  logic [7:0]       mask,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic             blank,
    output logic             frame_done
);

    localparam int BW = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             blank_q, blank_d;
    logic             fd_q, fd_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;

    logic [3:0]       first_pos;
    logic [3:0]       step_pos;
    logic             wrap;

    // Returns {found, pos}: nearest set mask bit strictly after start in dir
    // order, wrapping round to start itself last.
    function automatic logic [3:0] next_active(input logic [2:0] start,
                                               input logic       d,
                                               input logic [7:0] m);
        logic [3:0] res;
        logic [2:0] p;
        res = '0;
        for (int unsigned k = 8; k >= 1; k--) begin
            p = d ? (start - 3'(k)) : (start + 3'(k));
            if (m[p]) res = {1'b1, p};
        end
        return res;
    endfunction

    // Searching "after" 7 upward (or "after" 0 downward) visits 0..7 (or 7..0),
    // which is exactly the first-position search out of IDLE.
    assign first_pos = next_active(dir ? 3'd0 : 3'd7, dir, mask);
    assign step_pos  = next_active(idx_q, dir, mask);
    assign wrap      = dir ? (step_pos[2:0] >= idx_q) : (step_pos[2:0] <= idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        fd_d    = 1'b0;
        dwell_d = dwell_q;
        bcnt_d  = bcnt_q;
        if (!en) begin
            state_d = IDLE;
            blank_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    blank_d = 1'b1;
                    if (first_pos[3]) begin
                        idx_d = first_pos[2:0];
                        if (BLANK_CYC == 0) begin
                            state_d = SHOW;
                            blank_d = 1'b0;
                            dwell_d = div;
                        end else begin
                            state_d = BLANK;
                            bcnt_d  = BLANK_LOAD;
                        end
                    end
                end
                BLANK: begin
                    if (bcnt_q == '0) begin
                        state_d = SHOW;
                        blank_d = 1'b0;
                        dwell_d = div;
                    end else begin
                        bcnt_d = bcnt_q - 1'b1;
                    end
                end
                SHOW: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else if (!step_pos[3]) begin
                        state_d = IDLE;
                        blank_d = 1'b1;
                    end else begin
                        idx_d = step_pos[2:0];
                        fd_d  = wrap;
                        if (BLANK_CYC == 0) begin
                            dwell_d = div;
                        end else begin
                            state_d = BLANK;
                            blank_d = 1'b1;
                            bcnt_d  = BLANK_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    blank_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            blank_q <= 1'b1;
            fd_q    <= 1'b0;
            dwell_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            fd_q    <= fd_d;
            dwell_q <= dwell_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign sel1       = idx_q[2];
    assign sel2       = idx_q[1];
    assign sel3       = idx_q[0];
    assign blank      = blank_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_index_gen.sv
// Bench for scan_index_gen: directed scenarios plus randomized scans, all checked
// against an arithmetic model of the scan schedule.
module tb_scan_index_gen;

    localparam int BLANK = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic [15:0] div   = '0;
    logic        dir   = 1'b0;
    logic [7:0]  mask  = '0;
    logic        sel1, sel2, sel3, blank, frame_done;
    logic [4:0]  obs;

    int checks = 0;
    int errors = 0;

    scan_index_gen #(.DIV_W(16), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .dir(dir), .mask(mask),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .blank(blank), .frame_done(frame_done)
    );

    assign obs = {sel1, sel2, sel3, blank, frame_done};

    always #5 clk = ~clk;

    // Expected {sel, blank, frame_done} c cycles after the enabling edge, for a
    // scan with constant mask/div/dir: digits follow the ordered active list.
    function automatic logic [4:0] model_out(int c, logic [7:0] m, int dv, logic d);
        int seq[$];
        int per, n, r, s;
        logic b, f;
        for (int i = 0; i < 8; i++) begin
            int p;
            p = d ? 7 - i : i;
            if (m[p]) seq.push_back(p);
        end
        per = BLANK + dv + 1;
        n   = c / per;
        r   = c % per;
        s   = seq[n % seq.size()];
        b   = (r < BLANK);
        f   = (r == 0) && (n > 0) && ((n % seq.size()) == 0);
        return {s[2:0], b, f};
    endfunction

    task automatic go_idle();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b000_1_0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs, 5'b000_1_0);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b000_1_0) begin
                errors++;
                $display("FAIL reset_hold got=%b exp=%b", obs, 5'b000_1_0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        logic [4:0] e;
        int pulses = 0;
        mask = 8'hFF; div = 3; dir = 1'b0; en = 1'b1;
        for (int c = 0; c < 6 * 9 + 1; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            if (frame_done === 1'b1 && c < 54) pulses++;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ascending c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ascending_pulses got=%0d exp=1", pulses);
        end
        go_idle();
    endtask

    task automatic test_masked_desc();
        logic [4:0] e;
        mask = 8'b0010_0100; div = 3; dir = 1'b1; en = 1'b1;
        for (int c = 0; c < 6 * 4 + 1; c++) begin
            @(negedge clk);
            e = model_out(c, 8'b0010_0100, 3, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL masked_desc c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go_idle();
    endtask

    task automatic test_single();
        logic [4:0] e;
        mask = 8'h08; div = 0; dir = 1'b0; en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = {3'd3, (c % 3) < 2, (c % 3 == 0) && (c > 0)};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL single c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        logic [4:0] e;
        mask = 8'hFF; div = 3; dir = 1'b0; en = 1'b1;
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL en_drop_run c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b100_1_0) begin
                errors++;
                $display("FAIL en_drop_idle got=%b exp=%b", obs, 5'b100_1_0);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL en_restart c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go_idle();
    endtask

    task automatic test_no_active();
        logic [4:0] e;
        mask = 8'h00; div = 2; dir = 1'b0; en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (obs[1:0] !== 2'b10) begin
                errors++;
                $display("FAIL no_active got blank/fd=%b exp=10", obs[1:0]);
            end
        end
        mask = 8'h80;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = model_out(c, 8'h80, 2, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL no_active_start c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go_idle();
    endtask

    task automatic test_mask_clear();
        logic [4:0] e;
        mask = 8'hFF; div = 1; dir = 1'b0; en = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 1, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mask_clear_run c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        mask = 8'h00;
        @(negedge clk);
        checks++;
        if (obs !== 5'b010_0_0) begin
            errors++;
            $display("FAIL mask_clear_finish got=%b exp=%b", obs, 5'b010_0_0);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b010_1_0) begin
                errors++;
                $display("FAIL mask_clear_idle got=%b exp=%b", obs, 5'b010_1_0);
            end
        end
        go_idle();
    endtask

    task automatic test_dir_change();
        logic [4:0] e;
        int dseq[5] = '{2, 1, 0, 7, 6};
        mask = 8'hFF; div = 3; dir = 1'b0; en = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL dir_pre c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        dir = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b011_0_0) begin
                errors++;
                $display("FAIL dir_dwell got=%b exp=%b", obs, 5'b011_0_0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 6; r++) begin
                int s;
                s = dseq[k];
                @(negedge clk);
                e = {s[2:0], r < BLANK, (r == 0) && (s == 7)};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL dir_post k=%0d r=%0d got=%b exp=%b", k, r, obs, e);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_reset_midrun();
        logic [4:0] e;
        mask = 8'hFF; div = 3; dir = 1'b0; en = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_pre c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b000_1_0) begin
            errors++;
            $display("FAIL reset_midrun got=%b exp=%b", obs, 5'b000_1_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = model_out(c, 8'hFF, 3, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_restart c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [4:0] e;
        logic [7:0] m;
        int dv, ncyc;
        logic d;
        for (int it = 0; it < 8; it++) begin
            m  = 8'($urandom_range(1, 255));
            dv = $urandom_range(0, 4);
            d  = 1'($urandom_range(0, 1));
            ncyc = 2 * $countones(m) * (BLANK + dv + 1) + 3;
            mask = m; div = 16'(dv); dir = d; en = 1'b1;
            for (int c = 0; c < ncyc; c++) begin
                @(negedge clk);
                e = model_out(c, m, dv, d);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL random it=%0d mask=%h div=%0d dir=%0b c=%0d got=%b exp=%b",
                             it, m, dv, d, c, obs, e);
                end
            end
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_masked_desc();
        test_single();
        test_enable_drop();
        test_no_active();
        test_mask_clear();
        test_dir_change();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
